symmetry_stats: RTL and testbench

Downstream consumer of the 8-bit symmetry detector. Each valid cycle it takes one result: symmetric flag plus mismatched-pair count, 0–4. It keeps saturating statistics: total words, symmetric words, current and maximum symmetric streak, and an optional mismatch histogram. It also runs a small alarm state machine that fires on sustained asymmetry. Results are exposed through a select/read port, so the top level can multiplex them onto `uo_out`.

---
 rtl/symmetry_stats_pkg.sv | 19 +
 rtl/sat_counter.sv | 33 +++
 rtl/symmetry_stats.sv | 162 ++++++++++++++++
 tb/tb_symmetry_stats.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/symmetry_stats_pkg.sv
// Shared types and constants for the symmetry statistics block.
package symmetry_stats_pkg;

    typedef enum logic [1:0] {StIdle, StArming, StAlarm} alarm_state_e;

    localparam logic [3:0] SEL_TOTAL      = 4'd0;
    localparam logic [3:0] SEL_SYM        = 4'd1;
    localparam logic [3:0] SEL_STREAK     = 4'd2;
    localparam logic [3:0] SEL_MAX_STREAK = 4'd3;
    localparam logic [3:0] SEL_HIST0      = 4'd8;
    localparam logic [3:0] SEL_HIST4      = 4'd12;

    localparam logic [2:0] MISM_MAX = 3'd4;

    function automatic logic [2:0] clamp_mism(input logic [2:0] m);
        return (m > MISM_MAX) ? MISM_MAX : m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/symmetry_stats.sv
// Saturating statistics and asymmetry alarm for symmetry-detector results.
// Optional mismatch histogram enabled by defining SYMMETRY_STATS_HIST_EN.
module symmetry_stats
    import symmetry_stats_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ALARM_RUN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sym,
    input  logic [2:0]       in_mism,
    input  logic             clr,
    input  logic [2:0]       alarm_thr,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             alarm,
    output logic             err
);

    localparam logic [2:0] RUN_LIM = 3'(ALARM_RUN);

    logic             accept;
    logic [2:0]       mism_c;
    logic             bad;
    logic [CNT_W-1:0] total, sym_cnt, streak, streak_nxt;
    logic [CNT_W-1:0] max_streak_q;
    logic             err_q;
    alarm_state_e     state_q, state_d;
    logic [2:0]       run_q, run_d;

    assign accept = in_valid & ~clr;
    assign mism_c = clamp_mism(in_mism);
    assign bad    = (alarm_thr != 3'd0) && (mism_c >= alarm_thr);

    sat_counter #(.W(CNT_W)) u_total (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (accept),
        .count (total)
    );

    sat_counter #(.W(CNT_W)) u_sym (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (accept & in_sym),
        .count (sym_cnt)
    );

    // An asymmetric word restarts the streak through the counter's clear.
    sat_counter #(.W(CNT_W)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr | (accept & ~in_sym)),
        .inc   (accept & in_sym),
        .count (streak)
    );

    // Value the streak counter will hold after this word, for the max tracker.
    assign streak_nxt = !in_sym ? '0 :
                        (streak == {CNT_W{1'b1}}) ? streak : streak + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            max_streak_q <= '0;
            err_q        <= 1'b0;
        end else if (accept) begin
            if (streak_nxt > max_streak_q) begin
                max_streak_q <= streak_nxt;
            end
            if ((in_mism > MISM_MAX) || (in_sym != (mism_c == 3'd0))) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= StIdle;
            run_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (bad) begin
                        run_d   = 3'd1;
                        state_d = (RUN_LIM == 3'd1) ? StAlarm : StArming;
                    end
                end
                StArming: begin
                    if (bad) begin
                        run_d = run_q + 3'd1;
                        if (run_d == RUN_LIM) begin
                            state_d = StAlarm;
                        end
                    end else begin
                        run_d   = 3'd0;
                        state_d = StIdle;
                    end
                end
                StAlarm: begin
                    if (in_sym) begin
                        run_d   = 3'd0;
                        state_d = StIdle;
                    end
                end
                default: begin
                    run_d   = 3'd0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        alarm = (state_q == StAlarm);
        err   = err_q;
    end

`ifdef SYMMETRY_STATS_HIST_EN
    logic [CNT_W-1:0] hist [5];

    for (genvar b = 0; b < 5; b++) begin : g_hist
        sat_counter #(.W(CNT_W)) u_bin (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (accept && (mism_c == 3'(b))),
            .count (hist[b])
        );
    end
`endif

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_TOTAL:      rd_data = total;
            SEL_SYM:        rd_data = sym_cnt;
            SEL_STREAK:     rd_data = streak;
            SEL_MAX_STREAK: rd_data = max_streak_q;
            default: begin
`ifdef SYMMETRY_STATS_HIST_EN
                if ((rd_sel >= SEL_HIST0) && (rd_sel <= SEL_HIST4)) begin
                    rd_data = hist[rd_sel[2:0]];
                end
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_symmetry_stats.sv
// Bench for symmetry_stats: CNT_W=8 and CNT_W=4 instances against an unbounded-count model.
module tb_symmetry_stats;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sym;
    logic [2:0] in_mism;
    logic       clr;
    logic [2:0] alarm_thr;
    logic [3:0] rd_sel;
    logic [7:0] rd8;
    logic [3:0] rd4;
    logic       alarm8, alarm4, err8, err4;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    localparam int ARUN = 3;

    // Model: true (unbounded) counts; saturation is applied when reading.
    int m_total, m_sym, m_streak, m_max, m_run;
    int m_hist[5];
    bit m_err, m_alarm;

    always #5 clk = ~clk;

    symmetry_stats #(.CNT_W(8), .ALARM_RUN(ARUN)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_mism   (in_mism),
        .clr       (clr),
        .alarm_thr (alarm_thr),
        .rd_sel    (rd_sel),
        .rd_data   (rd8),
        .alarm     (alarm8),
        .err       (err8)
    );

    symmetry_stats #(.CNT_W(4), .ALARM_RUN(ARUN)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_mism   (in_mism),
        .clr       (clr),
        .alarm_thr (alarm_thr),
        .rd_sel    (rd_sel),
        .rd_data   (rd4),
        .alarm     (alarm4),
        .err       (err4)
    );

    task automatic model_reset();
        m_total = 0; m_sym = 0; m_streak = 0; m_max = 0; m_run = 0;
        m_err = 1'b0; m_alarm = 1'b0;
        for (int i = 0; i < 5; i++) m_hist[i] = 0;
    endtask

    task automatic model_step();
        int mc;
        bit bad;
        if (rst || clr) begin
            model_reset();
        end else if (in_valid) begin
            mc  = (int'(in_mism) > 4) ? 4 : int'(in_mism);
            bad = (alarm_thr != 0) && (mc >= int'(alarm_thr));
            m_total++;
            if (in_sym) begin
                m_sym++;
                m_streak++;
            end else begin
                m_streak = 0;
            end
            if (m_streak > m_max) m_max = m_streak;
            m_hist[mc]++;
            if (int'(in_mism) > 4 || (in_sym != (mc == 0))) m_err = 1'b1;
            if (m_alarm) begin
                if (in_sym) begin
                    m_alarm = 1'b0;
                    m_run   = 0;
                end
            end else if (bad) begin
                m_run++;
                if (m_run >= ARUN) m_alarm = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int expect_rd(input logic [3:0] sel, input int mx);
        int idx;
        idx = int'(sel);
        case (idx)
            0: return sat(m_total, mx);
            1: return sat(m_sym, mx);
            2: return sat(m_streak, mx);
            3: return sat(m_max, mx);
`ifdef SYMMETRY_STATS_HIST_EN
            8, 9, 10, 11, 12: return sat(m_hist[idx - 8], mx);
`endif
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s sel=%0d got %0d want %0d at %0t", name, rd_sel, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every negedge once reset has been applied.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check("rd_w8", {24'b0, rd8}, expect_rd(rd_sel, 255));
                check("rd_w4", {28'b0, rd4}, expect_rd(rd_sel, 15));
                check("alarm_w8", {31'b0, alarm8}, {31'b0, m_alarm});
                check("alarm_w4", {31'b0, alarm4}, {31'b0, m_alarm});
                check("err_w8", {31'b0, err8}, {31'b0, m_err});
                check("err_w4", {31'b0, err4}, {31'b0, m_err});
            end
        end
    end

    task automatic word(input bit s, input int m);
        in_valid = 1'b1;
        in_sym   = s;
        in_mism  = 3'(m);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rd_sel   = rd_sel + 4'd1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
    endtask

    task automatic idle_sweep();
        for (int i = 0; i < 16; i++) begin
            rd_sel = 4'(i);
            @(posedge clk);
            #2;
        end
    endtask

    // Hand-computed literal expectations against both widths.
    task automatic pin(input string name, input logic [3:0] sel, input int w8, input int w4);
        rd_sel = sel;
        #1;
        check({name, "_w8"}, {24'b0, rd8}, w8);
        check({name, "_w4"}, {28'b0, rd4}, w4);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sym = 1'b0; in_mism = 3'd0;
        clr = 1'b0; alarm_thr = 3'd0; rd_sel = 4'd0;
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        armed = 1'b1;

        // Reset state
        idle_sweep();
        pin("rst_total", 4'd0, 0, 0);
        pin("rst_max", 4'd3, 0, 0);
        pin("rst_hist0", 4'd8, 0, 0);
        check("rst_alarm", {31'b0, alarm8}, 0);
        check("rst_err", {31'b0, err8}, 0);

        // Streak
        word(1, 0); word(1, 0); word(0, 2); word(1, 0);
        pin("streak_total", 4'd0, 4, 4);
        pin("streak_sym", 4'd1, 3, 3);
        pin("streak_cur", 4'd2, 1, 1);
        pin("streak_max", 4'd3, 2, 2);
        idle_sweep();

        // Alarm: 2,3,4 raises, (0,1) holds, (1,0) releases
        do_clr();
        alarm_thr = 3'd2;
        word(0, 2); word(0, 3);
        check("alarm_early", {31'b0, alarm8}, 0);
        word(0, 4);
        check("alarm_raise", {31'b0, alarm8}, 1);
        word(0, 1);
        check("alarm_hold", {31'b0, alarm8}, 1);
        word(1, 0);
        check("alarm_release", {31'b0, alarm8}, 0);
        word(0, 2); word(0, 1); word(0, 2);
        check("alarm_broken_run", {31'b0, alarm4}, 0);
        word(0, 3); word(0, 4);
        check("alarm_rerun", {31'b0, alarm4}, 1);
        do_clr();
        alarm_thr = 3'd0;
        repeat (4) word(0, 4);
        check("alarm_disabled", {31'b0, alarm8}, 0);

        // Errors
        do_clr();
        word(1, 2);
        check("err_incons", {31'b0, err8}, 1);
        word(1, 0);
        check("err_sticky", {31'b0, err4}, 1);
        do_clr();
        check("err_cleared", {31'b0, err8}, 0);
        word(0, 6);
        check("err_illegal", {31'b0, err8}, 1);
`ifdef SYMMETRY_STATS_HIST_EN
        pin("hist_clamp", 4'd12, 1, 1);
`else
        pin("hist_absent", 4'd12, 0, 0);
`endif
        do_clr();
        word(0, 0);
        check("err_sym0_mism0", {31'b0, err4}, 1);
        idle_sweep();

        // Saturation
        do_clr();
        repeat (20) word(1, 0);
        pin("sat_total", 4'd0, 20, 15);
        pin("sat_streak", 4'd2, 20, 15);
        pin("sat_max", 4'd3, 20, 15);
        word(0, 1);
        pin("sat_streak_rst", 4'd2, 0, 0);
        pin("sat_max_keep", 4'd3, 20, 15);
        idle_sweep();

        // Clear collision
        do_clr();
        word(1, 0); word(1, 0);
        clr = 1'b1; in_valid = 1'b1; in_sym = 1'b1; in_mism = 3'd0;
        @(posedge clk);
        #2;
        clr = 1'b0; in_valid = 1'b0;
        pin("coll_total", 4'd0, 0, 0);
        pin("coll_sym", 4'd1, 0, 0);
        pin("coll_streak", 4'd2, 0, 0);
        pin("coll_hist0", 4'd8, 0, 0);

        // Mixed deterministic vectors, threshold changing mid-run
        for (int i = 0; i < 96; i++) begin
            int m;
            m = (i * 5 + i / 7) % 8;
            alarm_thr = 3'((i / 16) % 5);
            rd_sel    = 4'(i % 16);
            word((m == 0) ^ (i % 11 == 10), m);
        end
        idle_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
